// File: rtl/tl45_muldiv_seq_if.sv
// Execute-stage bus between the TL45 pipeline and the multi-cycle MUL/DIVU sequencer.
interface tl45_muldiv_seq_if;
    logic        i_pipe_stall;
    logic        o_pipe_stall;
    logic        i_pipe_flush;
    logic        o_pipe_flush;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr;
    logic [31:0] i_sr1_val;
    logic [31:0] i_sr2_val;
    logic [3:0]  o_of_reg;
    logic [31:0] o_of_val;
    logic [3:0]  o_dr;
    logic [31:0] o_value;
    logic        o_busy;

    modport master (
        output i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1_val, i_sr2_val,
        input  o_pipe_stall, o_pipe_flush, o_of_reg, o_of_val, o_dr, o_value, o_busy
    );

    modport slave (
        input  i_pipe_stall, i_pipe_flush, i_opcode, i_dr, i_sr1_val, i_sr2_val,
        output o_pipe_stall, o_pipe_flush, o_of_reg, o_of_val, o_dr, o_value, o_busy
    );
endinterface

// File: rtl/tl45_muldiv_seq.sv
// Multi-cycle MUL / DIVU sequencer for the TL45 execute stage (32 iterations per op).
// Define TL45_MULDIV_DIVIDE_EN to build in the restoring divider; otherwise DIVU is a bubble.
module tl45_muldiv_seq #(
    parameter logic [4:0] OP_MUL  = 5'h3,
    parameter logic [4:0] OP_DIVU = 5'h4
) (
    input logic              i_clk,
    input logic              i_reset,
    tl45_muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_drLatch;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [31:0] r_acc;
    logic [4:0]  r_count;
    logic [3:0]  r_dr;
    logic [31:0] r_value;
    logic        w_isMd;
    logic        w_start;
    logic [31:0] w_mulAcc;

`ifdef TL45_MULDIV_DIVIDE_EN
    logic        r_isDiv;
    logic [31:0] r_rem;
    logic [32:0] w_remShift;
    logic        w_qBit;

    assign w_isMd     = (bus.i_opcode == OP_MUL) || (bus.i_opcode == OP_DIVU);
    // The shifted remainder can reach 33 bits when the divisor is above 2^31.
    assign w_remShift = {r_rem, r_opA[31]};
    assign w_qBit     = (w_remShift >= {1'b0, r_opB});
`else
    assign w_isMd = (bus.i_opcode == OP_MUL) && (bus.i_opcode != OP_DIVU);
`endif

    assign w_start  = (r_state == IDLE) && w_isMd && !bus.i_pipe_stall && !bus.i_pipe_flush;
    assign w_mulAcc = r_opB[0] ? (r_acc + r_opA) : r_acc;

    assign bus.o_pipe_flush = bus.i_pipe_flush;
    assign bus.o_busy       = (r_state != IDLE);
    assign bus.o_dr         = r_dr;
    assign bus.o_value      = r_value;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Stall is released in DONE so upstream moves past the op that is finishing.
    always_comb begin
        w_nextState      = r_state;
        bus.o_pipe_stall = bus.i_pipe_stall;
        bus.o_of_reg     = 4'd0;
        bus.o_of_val     = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_isMd) begin
                    bus.o_pipe_stall = 1'b1;
                end
                if (w_start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                bus.o_pipe_stall = 1'b1;
                if (r_count == 5'd31) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                bus.o_of_reg = r_drLatch;
                bus.o_of_val = r_acc;
                if (!bus.i_pipe_stall) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (bus.i_pipe_flush) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_drLatch <= 4'd0;
            r_opA     <= 32'd0;
            r_opB     <= 32'd0;
            r_acc     <= 32'd0;
            r_count   <= 5'd0;
            r_dr      <= 4'd0;
            r_value   <= 32'd0;
`ifdef TL45_MULDIV_DIVIDE_EN
            r_isDiv   <= 1'b0;
            r_rem     <= 32'd0;
`endif
        end else if (bus.i_pipe_flush) begin
            r_dr    <= 4'd0;
            r_value <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_drLatch <= bus.i_dr;
                        r_opA     <= bus.i_sr1_val;
                        r_opB     <= bus.i_sr2_val;
                        r_acc     <= 32'd0;
                        r_count   <= 5'd0;
                        r_dr      <= 4'd0;
                        r_value   <= 32'd0;
`ifdef TL45_MULDIV_DIVIDE_EN
                        r_isDiv   <= (bus.i_opcode == OP_DIVU);
                        r_rem     <= 32'd0;
`endif
                    end else if (!bus.i_pipe_stall) begin
                        r_dr    <= 4'd0;
                        r_value <= 32'd0;
                    end
                end
                RUN: begin
                    r_count <= r_count + 5'd1;
`ifdef TL45_MULDIV_DIVIDE_EN
                    if (r_isDiv) begin
                        r_opA <= {r_opA[30:0], 1'b0};
                        r_rem <= w_qBit ? (w_remShift[31:0] - r_opB) : w_remShift[31:0];
                        r_acc <= {r_acc[30:0], w_qBit};
                    end else begin
                        r_acc <= w_mulAcc;
                        r_opA <= {r_opA[30:0], 1'b0};
                        r_opB <= {1'b0, r_opB[31:1]};
                    end
`else
                    r_acc <= w_mulAcc;
                    r_opA <= {r_opA[30:0], 1'b0};
                    r_opB <= {1'b0, r_opB[31:1]};
`endif
                end
                DONE: begin
                    if (!bus.i_pipe_stall) begin
                        r_dr    <= r_drLatch;
                        r_value <= r_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tl45_muldiv_seq.sv
// Directed self-checking bench for tl45_muldiv_seq; DIVU checks follow TL45_MULDIV_DIVIDE_EN.
module tb_tl45_muldiv_seq;
    localparam logic [4:0] OP_MUL  = 5'h3;
    localparam logic [4:0] OP_DIVU = 5'h4;
    localparam logic [4:0] OP_ADD  = 5'h1;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    tl45_muldiv_seq_if bus();

    tl45_muldiv_seq #(.OP_MUL(OP_MUL), .OP_DIVU(OP_DIVU)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveOp(input logic [4:0] op, input logic [3:0] dr,
                           input logic [31:0] a, input logic [31:0] b);
        bus.i_opcode  = op;
        bus.i_dr      = dr;
        bus.i_sr1_val = a;
        bus.i_sr2_val = b;
    endtask

    // Follows one op from cycle startC; presents the next op in the cycle after DONE.
    task automatic waitResult(input int startC,
                              input logic [4:0] nOp, input logic [3:0] nDr,
                              input logic [31:0] nA, input logic [31:0] nB,
                              output logic [31:0] fwdVal, output logic [3:0] resDr,
                              output logic [31:0] resVal, output int lat);
        bit doneSeen;
        bit nextDriven;
        doneSeen   = 0;
        nextDriven = 0;
        fwdVal     = 32'd0;
        resDr      = 4'd0;
        resVal     = 32'd0;
        lat        = -1;
        for (int c = startC; c <= 80; c++) begin
            if (c > startC) begin
                @(posedge clk); #1;
                if (doneSeen && !nextDriven) begin
                    driveOp(nOp, nDr, nA, nB);
                    nextDriven = 1;
                end
            end
            @(negedge clk);
            if (bus.o_busy && !bus.o_pipe_stall) begin
                doneSeen = 1;
                fwdVal   = bus.o_of_val;
            end
            if (bus.o_dr !== 4'd0) begin
                resDr  = bus.o_dr;
                resVal = bus.o_value;
                lat    = c;
                break;
            end
        end
    endtask

    task automatic runMd(input logic [4:0] op, input logic [3:0] dr,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] nOp, input logic [3:0] nDr,
                         input logic [31:0] nA, input logic [31:0] nB,
                         output logic [31:0] fwdVal, output logic [3:0] resDr,
                         output logic [31:0] resVal, output int lat);
        driveOp(op, dr, a, b);
        waitResult(0, nOp, nDr, nA, nB, fwdVal, resDr, resVal, lat);
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_dr !== 4'd0) begin errors++; $display("[TB] FAIL reset_dr: got %0d, expected 0", bus.o_dr); end
        checks++; if (bus.o_value !== 32'd0) begin errors++; $display("[TB] FAIL reset_value: got %0h, expected 0", bus.o_value); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.o_busy); end
        checks++; if (bus.o_pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b, expected 0", bus.o_pipe_stall); end
        checks++; if (bus.o_of_reg !== 4'd0 || bus.o_of_val !== 32'd0) begin errors++; $display("[TB] FAIL reset_fwd: got %0d/%0h, expected 0/0", bus.o_of_reg, bus.o_of_val); end
    endtask

    task automatic test_mul_basic();
        int badStall;
        badStall = 0;
        @(posedge clk); #1;
        driveOp(OP_MUL, 4'd3, 32'd7, 32'd6);
        @(negedge clk);
        if (bus.o_pipe_stall !== 1'b1) badStall++;
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.o_pipe_stall !== 1'b1 || bus.o_busy !== 1'b1) badStall++;
        end
        checks++; if (badStall !== 0) begin errors++; $display("[TB] FAIL mul_stall_run: got %0d low-stall cycles in 0-32, expected 0", badStall); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.o_pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL mul_done_stall: got %b, expected 0", bus.o_pipe_stall); end
        checks++; if (bus.o_of_reg !== 4'd3) begin errors++; $display("[TB] FAIL mul_fwd_reg: got %0d, expected 3", bus.o_of_reg); end
        checks++; if (bus.o_of_val !== 32'd42) begin errors++; $display("[TB] FAIL mul_fwd_val: got %0d, expected 42", bus.o_of_val); end
        @(posedge clk); #1;
        driveOp(5'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.o_dr !== 4'd3 || bus.o_value !== 32'd42) begin errors++; $display("[TB] FAIL mul_result: got dr=%0d val=%0d, expected dr=3 val=42", bus.o_dr, bus.o_value); end
        checks++; if (bus.o_of_reg !== 4'd0) begin errors++; $display("[TB] FAIL mul_fwd_after: got %0d, expected 0", bus.o_of_reg); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.o_dr !== 4'd0 || bus.o_value !== 32'd0) begin errors++; $display("[TB] FAIL mul_result_clear: got dr=%0d val=%0d, expected 0/0", bus.o_dr, bus.o_value); end
    endtask

    task automatic test_mul_vectors();
        logic [31:0] fwd;
        logic [3:0]  rdr;
        logic [31:0] rval;
        int          lat;
        @(posedge clk); #1;
        runMd(OP_MUL, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd1 || rval !== 32'h00000001) begin errors++; $display("[TB] FAIL mul_ffff: got dr=%0d val=%h, expected dr=1 val=00000001", rdr, rval); end
        checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL mul_latency: got %0d, expected 34", lat); end
        @(posedge clk); #1;
        runMd(OP_MUL, 4'd2, 32'h00010000, 32'h00010000, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd2 || rval !== 32'd0) begin errors++; $display("[TB] FAIL mul_wrap: got dr=%0d val=%h, expected dr=2 val=00000000", rdr, rval); end
        @(posedge clk); #1;
        runMd(OP_MUL, 4'd9, 32'd12345, 32'd1000, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rval !== 32'd12345000 || fwd !== 32'd12345000) begin errors++; $display("[TB] FAIL mul_12345x1000: got val=%0d fwd=%0d, expected 12345000", rval, fwd); end
    endtask

`ifdef TL45_MULDIV_DIVIDE_EN
    task automatic test_divu();
        logic [31:0] fwd;
        logic [3:0]  rdr;
        logic [31:0] rval;
        int          lat;
        @(posedge clk); #1;
        runMd(OP_DIVU, 4'd8, 32'd100, 32'd7, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd8 || rval !== 32'd14 || lat !== 34) begin errors++; $display("[TB] FAIL div_100_7: got dr=%0d val=%0d lat=%0d, expected 8/14/34", rdr, rval, lat); end
        @(posedge clk); #1;
        runMd(OP_DIVU, 4'd8, 32'd5, 32'd0, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rval !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_by_zero: got %h, expected FFFFFFFF", rval); end
        @(posedge clk); #1;
        runMd(OP_DIVU, 4'd8, 32'hFFFFFFFF, 32'h80000001, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rval !== 32'd1) begin errors++; $display("[TB] FAIL div_large_divisor: got %h, expected 00000001", rval); end
        @(posedge clk); #1;
        runMd(OP_DIVU, 4'd8, 32'd1000000, 32'd3, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rval !== 32'd333333) begin errors++; $display("[TB] FAIL div_1000000_3: got %0d, expected 333333", rval); end
    endtask
`else
    task automatic test_divu_disabled();
        logic [31:0] fwd;
        logic [3:0]  rdr;
        logic [31:0] rval;
        int          lat;
        @(posedge clk); #1;
        runMd(OP_MUL, 4'd9, 32'd4, 32'd5, OP_DIVU, 4'd6, 32'd100, 32'd7, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd9 || rval !== 32'd20) begin errors++; $display("[TB] FAIL nodiv_prev_mul: got dr=%0d val=%0d, expected 9/20", rdr, rval); end
        checks++; if (bus.o_pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL nodiv_stall: got %b, expected 0", bus.o_pipe_stall); end
        @(posedge clk); #1;
        driveOp(5'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.o_dr !== 4'd0 || bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL nodiv_bubble: got dr=%0d busy=%b, expected 0/0", bus.o_dr, bus.o_busy); end
    endtask
`endif

    task automatic test_flush();
        logic [31:0] fwd;
        logic [3:0]  rdr;
        logic [31:0] rval;
        int          lat;
        @(posedge clk); #1;
        driveOp(OP_MUL, 4'd4, 32'd9, 32'd9);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        bus.i_pipe_flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.o_pipe_flush !== 1'b1) begin errors++; $display("[TB] FAIL flush_passthru: got %b, expected 1", bus.o_pipe_flush); end
        @(posedge clk); #1;
        bus.i_pipe_flush = 1'b0;
        driveOp(OP_MUL, 4'd2, 32'd2, 32'd3);
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_dr !== 4'd0) begin errors++; $display("[TB] FAIL flush_idle: got busy=%b dr=%0d, expected 0/0", bus.o_busy, bus.o_dr); end
        @(posedge clk); #1;
        waitResult(1, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd2 || rval !== 32'd6) begin errors++; $display("[TB] FAIL flush_next_op: got dr=%0d val=%0d, expected 2/6", rdr, rval); end
        checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL flush_next_latency: got %0d, expected 34", lat); end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        for (int c = 0; c <= 39; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 0) driveOp(OP_MUL, 4'd7, 32'h1234, 32'h100);
            if (c == 38) driveOp(5'd0, 4'd0, 32'd0, 32'd0);
            bus.i_pipe_stall = (c >= 30 && c <= 36);
            @(negedge clk);
            if (c == 36) begin
                checks++; if (bus.o_busy !== 1'b1 || bus.o_of_val !== 32'h123400 || bus.o_dr !== 4'd0) begin errors++; $display("[TB] FAIL stall_done_hold: got busy=%b fwd=%h dr=%0d, expected 1/00123400/0", bus.o_busy, bus.o_of_val, bus.o_dr); end
            end
            if (c == 37) begin
                checks++; if (bus.o_pipe_stall !== 1'b0 || bus.o_dr !== 4'd0) begin errors++; $display("[TB] FAIL stall_release: got stall=%b dr=%0d, expected 0/0", bus.o_pipe_stall, bus.o_dr); end
            end
            if (c == 38) begin
                checks++; if (bus.o_dr !== 4'd7 || bus.o_value !== 32'h123400) begin errors++; $display("[TB] FAIL stall_result: got dr=%0d val=%h, expected 7/00123400", bus.o_dr, bus.o_value); end
            end
            if (c == 39) begin
                checks++; if (bus.o_dr !== 4'd0) begin errors++; $display("[TB] FAIL stall_result_clear: got %0d, expected 0", bus.o_dr); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fwd;
        logic [3:0]  rdr;
        logic [31:0] rval;
        int          lat;
        @(posedge clk); #1;
        runMd(OP_MUL, 4'd1, 32'd3, 32'd5, OP_MUL, 4'd2, 32'd4, 32'd4, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd1 || rval !== 32'd15) begin errors++; $display("[TB] FAIL b2b_first: got dr=%0d val=%0d, expected 1/15", rdr, rval); end
        checks++; if (bus.o_pipe_stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_stall: got %b, expected 1", bus.o_pipe_stall); end
        @(posedge clk); #1;
        waitResult(1, OP_ADD, 4'd5, 32'd1, 32'd2, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd2 || rval !== 32'd16 || lat !== 34) begin errors++; $display("[TB] FAIL b2b_second: got dr=%0d val=%0d lat=%0d, expected 2/16/34", rdr, rval, lat); end
        checks++; if (bus.o_pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL bubble_stall: got %b, expected 0", bus.o_pipe_stall); end
        @(posedge clk); #1;
        driveOp(5'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.o_dr !== 4'd0 || bus.o_value !== 32'd0) begin errors++; $display("[TB] FAIL bubble_output: got dr=%0d val=%0d, expected 0/0", bus.o_dr, bus.o_value); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] fwd;
        logic [3:0]  rdr;
        logic [31:0] rval;
        int          lat;
        @(posedge clk); #1;
        driveOp(OP_MUL, 4'd6, 32'd5, 32'd5);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        driveOp(5'd0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_busy: got %b, expected 1", bus.o_busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_busy !== 1'b0 || bus.o_pipe_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_state: got busy=%b stall=%b, expected 0/0", bus.o_busy, bus.o_pipe_stall); end
        checks++; if (bus.o_dr !== 4'd0 || bus.o_value !== 32'd0 || bus.o_of_val !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_outputs: got dr=%0d val=%0d fwd=%0d, expected 0/0/0", bus.o_dr, bus.o_value, bus.o_of_val); end
        @(posedge clk); #1;
        runMd(OP_MUL, 4'd6, 32'd5, 32'd5, 5'd0, 4'd0, 32'd0, 32'd0, fwd, rdr, rval, lat);
        checks++; if (rdr !== 4'd6 || rval !== 32'd25) begin errors++; $display("[TB] FAIL rst_recover: got dr=%0d val=%0d, expected 6/25", rdr, rval); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b1;
        bus.i_pipe_stall = 1'b0;
        bus.i_pipe_flush = 1'b0;
        driveOp(5'd0, 4'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        test_reset();
        test_mul_basic();
        test_mul_vectors();
`ifdef TL45_MULDIV_DIVIDE_EN
        test_divu();
`else
        test_divu_disabled();
`endif
        test_flush();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
